// File: rtl/mux_scan_pkg.sv
// Shared constants and state encoding for the mux channel scanner.
package mux_scan_pkg;

   localparam int NCH      = 8;
   localparam int CH_W     = 3;
   localparam int SETTLE_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      HOLD   = 2'd2
   } state_t;

endpackage

// File: rtl/mux_scan_next_ch.sv
// Rotate-priority encoder: next set bit of mask strictly above cur, wrapping.
// With cur = NCH-1 it returns the lowest set bit.
module mux_scan_next_ch
   import mux_scan_pkg::*;
(
   input  logic [NCH-1:0]  mask,
   input  logic [CH_W-1:0] cur,
   output logic [CH_W-1:0] nxt,
   output logic            wrap,
   output logic            none
);

   logic [CH_W-1:0] w_idx;

   // NOTE: every output gets a default before the loop so no path can infer a latch.
   always_comb begin
      nxt   = cur;
      wrap  = 1'b1;
      w_idx = '0;
      // Walk from farthest to nearest so the nearest set bit wins; i = NCH lands back on cur.
      for (int i = NCH; i >= 1; i--) begin
         w_idx = cur + CH_W'(i);
         if (mask[w_idx]) begin
            nxt  = w_idx;
            wrap = (w_idx <= cur);
         end
      end
      none = ~|mask;
   end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Round-robin scanner driving an 8:1 mux and streaming tagged samples.
// Optional macro MUX_SCAN_FRAME_CNT_EN adds a 16-bit frame counter output.
module mux_scan_ctrl
   import mux_scan_pkg::*;
#(
   parameter int WIDTH      = 8,
   parameter int SETTLE_CYC = 2
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             stop,
   input  logic [NCH-1:0]   ch_mask,
   output logic [CH_W-1:0]  addr,
   output logic             ncs,
   input  logic [WIDTH-1:0] mux_dout,
   output logic [WIDTH-1:0] out_data,
   output logic [CH_W-1:0]  out_ch,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             busy,
`ifdef MUX_SCAN_FRAME_CNT_EN
   output logic [15:0]      frame_cnt,
`endif
   output logic             frame_done
);

   state_t              r_state;
   logic [CH_W-1:0]     r_cur;
   logic [NCH-1:0]      r_mask_q;
   logic                r_stop_q;
   logic [SETTLE_W-1:0] r_cnt;
   logic                r_ncs;
   logic [WIDTH-1:0]    r_out_data;
   logic [CH_W-1:0]     r_out_ch;
   logic                r_out_valid;
   logic                r_frame_done;

   logic [CH_W-1:0]     w_nxt;
   logic                w_wrap;
   logic                w_unused_nxt_none;
   logic [CH_W-1:0]     w_first;
   logic                w_first_none;
   logic                w_unused_first_wrap;
   logic                w_hs;

   // Next channel within the latched frame mask.
   mux_scan_next_ch u_next (
      .mask (r_mask_q),
      .cur  (r_cur),
      .nxt  (w_nxt),
      .wrap (w_wrap),
      .none (w_unused_nxt_none)
   );

   // First channel of a new frame, taken from the live mask.
   mux_scan_next_ch u_first (
      .mask (ch_mask),
      .cur  (CH_W'(NCH - 1)),
      .nxt  (w_first),
      .wrap (w_unused_first_wrap),
      .none (w_first_none)
   );

   assign w_hs = r_out_valid && out_ready;

`ifdef MUX_SCAN_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (r_state == IDLE && start && !w_first_none) begin
         r_frame_cnt <= '0;
      end else if (r_state == HOLD && w_hs && w_wrap) begin
         r_frame_cnt <= r_frame_cnt + 16'd1;
      end
   end
   assign frame_cnt = r_frame_cnt;
`endif

   // NOTE: state registers use non-blocking assignments so every update sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cur        <= '0;
         r_mask_q     <= '0;
         r_stop_q     <= 1'b0;
         r_cnt        <= '0;
         r_ncs        <= 1'b1;
         r_out_data   <= '0;
         r_out_ch     <= '0;
         r_out_valid  <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         case (r_state)
            IDLE: begin
               r_stop_q <= 1'b0;
               r_ncs    <= 1'b1;
               if (start && !w_first_none) begin
                  r_mask_q <= ch_mask;
                  r_cur    <= w_first;
                  r_cnt    <= '0;
                  r_ncs    <= 1'b0;
                  r_state  <= SETTLE;
               end
            end
            SETTLE: begin
               if (stop) r_stop_q <= 1'b1;
               if (r_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                  r_out_data  <= mux_dout;
                  r_out_ch    <= r_cur;
                  r_out_valid <= 1'b1;
                  r_cnt       <= '0;
                  r_state     <= HOLD;
               end else begin
                  r_cnt <= r_cnt + SETTLE_W'(1);
               end
            end
            HOLD: begin
               if (stop) r_stop_q <= 1'b1;
               if (w_hs) begin
                  r_out_valid <= 1'b0;
                  if (w_wrap) begin
                     r_frame_done <= 1'b1;
                     r_mask_q     <= ch_mask;
                  end
                  if (r_stop_q || stop || (w_wrap && w_first_none)) begin
                     r_state  <= IDLE;
                     r_ncs    <= 1'b1;
                     r_stop_q <= 1'b0;
                  end else begin
                     r_cur   <= w_wrap ? w_first : w_nxt;
                     r_cnt   <= '0;
                     r_state <= SETTLE;
                  end
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign addr       = r_cur;
   assign ncs        = r_ncs;
   assign out_data   = r_out_data;
   assign out_ch     = r_out_ch;
   assign out_valid  = r_out_valid;
   assign busy       = (r_state != IDLE);
   assign frame_done = r_frame_done;

endmodule
